apu_pulse_gen3: RTL

Parametrised third-generation pulse (square) channel. One RTL source serves APU pulse 1, APU pulse 2 and sweep-less expansion pulses such as MMC5, selected by parameters. Over the gen2 channels it adds sequencer phase reset on the high-period write, a correct sweep-divider reload, and an optional sweep unit. It sits in the APU beside the triangle and noise channels and feeds the mixer and the $4015 status logic.

---
 rtl/apu_pkg.sv | 36 +++
 rtl/apu_envelope_generator_gen2.sv | 47 ++++
 rtl/apu_length_counter_gen2.sv | 24 ++
 rtl/apu_sweep_gen3.sv | 54 +++++
 rtl/apu_pulse_gen3.sv | 85 ++++++++
 5 files changed

// File: rtl/apu_pkg.sv
// Shared APU definitions: register selects, duty step masks and the length-counter load table.
package apu_pkg;

    localparam logic [1:0] REG_CTRL  = 2'd0;
    localparam logic [1:0] REG_SWEEP = 2'd1;
    localparam logic [1:0] REG_LO    = 2'd2;
    localparam logic [1:0] REG_HI    = 2'd3;

    // Bit s of the mask is the sequencer output at step s.
    function automatic logic duty_bit(input logic [1:0] duty, input logic [2:0] step);
        logic [7:0] mask;
        case (duty)
            2'd0:    mask = 8'b1000_0000;
            2'd1:    mask = 8'b1100_0000;
            2'd2:    mask = 8'b1111_0000;
            default: mask = 8'b0011_1111;
        endcase
        return mask[step];
    endfunction

    function automatic logic [7:0] length_lookup(input logic [4:0] idx);
        logic [7:0] val;
        case (idx)
            5'd0:  val = 8'd10;   5'd1:  val = 8'd254;  5'd2:  val = 8'd20;   5'd3:  val = 8'd2;
            5'd4:  val = 8'd40;   5'd5:  val = 8'd4;    5'd6:  val = 8'd80;   5'd7:  val = 8'd6;
            5'd8:  val = 8'd160;  5'd9:  val = 8'd8;    5'd10: val = 8'd60;   5'd11: val = 8'd10;
            5'd12: val = 8'd14;   5'd13: val = 8'd12;   5'd14: val = 8'd26;   5'd15: val = 8'd14;
            5'd16: val = 8'd12;   5'd17: val = 8'd16;   5'd18: val = 8'd24;   5'd19: val = 8'd18;
            5'd20: val = 8'd48;   5'd21: val = 8'd20;   5'd22: val = 8'd96;   5'd23: val = 8'd22;
            5'd24: val = 8'd192;  5'd25: val = 8'd24;   5'd26: val = 8'd72;   5'd27: val = 8'd26;
            5'd28: val = 8'd16;   5'd29: val = 8'd28;   5'd30: val = 8'd32;   default: val = 8'd30;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/apu_envelope_generator_gen2.sv
// Envelope: constant volume or a 15..0 decay clocked by the quarter-frame pulse, optionally looping.
module apu_envelope_generator_gen2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       e_pulse,
    input  logic       wr_ctrl,
    input  logic [5:0] din,
    input  logic       restart,
    output logic [3:0] env_out
);
    logic       loop_flag, const_vol, start;
    logic [3:0] vol, divider, decay;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            loop_flag <= 1'b0;
            const_vol <= 1'b0;
            vol       <= 4'd0;
            start     <= 1'b0;
            divider   <= 4'd0;
            decay     <= 4'd0;
        end else begin
            if (wr_ctrl) begin
                loop_flag <= din[5];
                const_vol <= din[4];
                vol       <= din[3:0];
            end
            if (restart) begin
                start <= 1'b1;
            end else if (e_pulse) begin
                if (start) begin
                    start   <= 1'b0;
                    decay   <= 4'd15;
                    divider <= vol;
                end else if (divider == 4'd0) begin
                    divider <= vol;
                    if (decay != 4'd0) decay <= decay - 4'd1;
                    else if (loop_flag) decay <= 4'd15;
                end else begin
                    divider <= divider - 4'd1;
                end
            end
        end
    end

    assign env_out = const_vol ? vol : decay;
endmodule

// File: rtl/apu_length_counter_gen2.sv
// Length counter: table load on the high-period write, half-frame countdown, forced clear when disabled.
module apu_length_counter_gen2
    import apu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       len_en,
    input  logic       l_pulse,
    input  logic       halt,
    input  logic       load,
    input  logic [4:0] load_idx,
    output logic       active
);
    logic [7:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                      count <= 8'd0;
        else if (!len_en)                             count <= 8'd0;
        else if (load)                                count <= length_lookup(load_idx);
        else if (l_pulse && count != 8'd0 && !halt)   count <= count - 8'd1;
    end

    assign active = (count != 8'd0);
endmodule

// File: rtl/apu_sweep_gen3.sv
// Sweep unit: divider with reload flag, combinational target period and mute detection.
module apu_sweep_gen3 #(
    parameter int TIMER_W       = 11,
    parameter int NEG_ONES_COMP = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               l_pulse,
    input  logic               wr,
    input  logic [7:0]         din,
    input  logic [TIMER_W-1:0] period,
    output logic               mute,
    output logic               update,
    output logic [TIMER_W-1:0] target
);
    logic         en_r, neg_r, reload;
    logic [2:0]   p_r, s_r, divider;
    logic [TIMER_W-1:0] change;
    logic [TIMER_W:0]   sum, tgt_full;
    logic [TIMER_W+1:0] diff;

    assign change = period >> s_r;
    assign sum    = {1'b0, period} + {1'b0, change};
    assign diff   = {2'b00, period} - {2'b00, change}
                  - {{(TIMER_W+1){1'b0}}, (NEG_ONES_COMP != 0)};
    // Negative results clamp to zero rather than wrapping.
    assign tgt_full = neg_r ? (diff[TIMER_W+1] ? '0 : diff[TIMER_W:0]) : sum;
    assign target   = tgt_full[TIMER_W-1:0];
    assign mute     = (period < TIMER_W'(8)) || (!neg_r && tgt_full[TIMER_W]);
    assign update   = l_pulse && (divider == 3'd0) && en_r && (s_r != 3'd0) && !mute;

    // A coincident register write lands while the half-frame step uses the old values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_r    <= 1'b0;
            p_r     <= 3'd0;
            neg_r   <= 1'b0;
            s_r     <= 3'd0;
            divider <= 3'd0;
            reload  <= 1'b0;
        end else begin
            if (l_pulse) begin
                if (divider == 3'd0 || reload) divider <= p_r;
                else                           divider <= divider - 3'd1;
            end
            if (wr) begin
                {en_r, p_r, neg_r, s_r} <= din;
                reload <= 1'b1;
            end else if (l_pulse && (divider == 3'd0 || reload)) begin
                reload <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/apu_pulse_gen3.sv
// Pulse (square) channel: timer, 8-step duty sequencer, optional sweep, envelope and length counter.
module apu_pulse_gen3
    import apu_pkg::*;
#(
    parameter int TIMER_W       = 11,
    parameter int SWEEP_EN      = 1,
    parameter int NEG_ONES_COMP = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pulse_en,
    input  logic               apu_clk,
    input  logic               l_pulse,
    input  logic               e_pulse,
    input  logic [1:0]         a_in,
    input  logic [7:0]         from_cpu,
    input  logic               wren,
    output logic [3:0]         pulse_out,
    output logic               active_out,
    output logic [TIMER_W-1:0] period_out
);
    logic wr_ctrl, wr_sweep, wr_lo, wr_hi;
    logic [TIMER_W-1:0] period, period_nxt, count, sw_target;
    logic [1:0] duty;
    logic [2:0] step;
    logic halt, timer_pulse, seq_bit, sw_mute, sw_update, mute, sweep_upd;
    logic [3:0] env;

    assign wr_ctrl  = wren && (a_in == REG_CTRL);
    assign wr_sweep = wren && (a_in == REG_SWEEP) && (SWEEP_EN != 0);
    assign wr_lo    = wren && (a_in == REG_LO);
    assign wr_hi    = wren && (a_in == REG_HI);

    apu_sweep_gen3 #(.TIMER_W(TIMER_W), .NEG_ONES_COMP(NEG_ONES_COMP)) u_sweep (
        .clk(clk), .rst_n(rst), .l_pulse(l_pulse), .wr(wr_sweep), .din(from_cpu),
        .period(period), .mute(sw_mute), .update(sw_update), .target(sw_target)
    );

    assign mute      = (SWEEP_EN != 0) && sw_mute;
    assign sweep_upd = (SWEEP_EN != 0) && sw_update;

    // CPU bytes override the sweep result only in the bits they write.
    always_comb begin
        period_nxt = period;
        if (sweep_upd) period_nxt = sw_target;
        if (wr_lo)     period_nxt[7:0] = from_cpu;
        if (wr_hi)     period_nxt[TIMER_W-1:8] = from_cpu[TIMER_W-9:0];
    end

    assign timer_pulse = apu_clk && (count == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            period <= '0;
            count  <= '0;
            duty   <= 2'd0;
            halt   <= 1'b0;
            step   <= 3'd0;
        end else begin
            period <= period_nxt;
            if (apu_clk) count <= timer_pulse ? period : count - 1'b1;
            if (wr_ctrl) begin
                duty <= from_cpu[7:6];
                halt <= from_cpu[5];
            end
            if (wr_hi)            step <= 3'd0;
            else if (timer_pulse) step <= step - 3'd1;
        end
    end

    assign seq_bit = duty_bit(duty, step);

    apu_envelope_generator_gen2 u_env (
        .clk(clk), .rst(~rst), .e_pulse(e_pulse), .wr_ctrl(wr_ctrl),
        .din(from_cpu[5:0]), .restart(wr_hi), .env_out(env)
    );

    apu_length_counter_gen2 u_len (
        .clk(clk), .rst(~rst), .len_en(pulse_en), .l_pulse(l_pulse), .halt(halt),
        .load(wr_hi), .load_idx(from_cpu[7:3]), .active(active_out)
    );

    assign pulse_out  = env & {4{seq_bit & active_out & ~mute}};
    assign period_out = period;
endmodule
